dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access controller directly downstream of the EX/MEM pipeline register.
- Takes MemRead/MemWrite, the ALU-computed address and store data for the instruction in MEM, and runs a req/ack transaction on an external data-memory bus.
- Holds the pipeline with a stall output until the transaction finishes.
- Delivers 64-bit load data to the MEM/WB register and flags misaligned or timed-out accesses.

Parameters:
ADDR_W, 64, width of byte address from ALU result
DATA_W, 64, width of load/store data (doubleword)
TIMEOUT, 15, max cycles in BUS state without bus_ack before abort (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
mem_read  in  1  MemRead from EX/MEM control
mem_write  in  1  MemWrite from EX/MEM control
addr  in  ADDR_W  ALU result from EX/MEM (byte address)
wdata  in  DATA_W  store data from EX/MEM
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
rdata  out  DATA_W  load result to MEM/WB Mem input
err  out  1  one-cycle pulse: misaligned, conflicting, or timed-out access
bus_req  out  1  bus request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_ack  in  1  bus completion; accepted only while bus_req=1
bus_rdata  in  DATA_W  read data, valid in bus_ack cycle

Behaviour:
- States: IDLE, BUS, DONE.
- Reset (rst=0 at a rising edge):
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, err=0, timeout counter=0.
  - Reset mid-transaction drops bus_req on that edge.
  - A late bus_ack after reset is ignored.
- op = mem_read | mem_write.
- bad = (addr[2:0] != 0) | (mem_read & mem_write).
- IDLE:
  - op & !bad: stall=1 combinationally in the same cycle. At the edge, latch bus_we=mem_write, bus_addr=addr, bus_wdata=wdata, set bus_req=1, clear counter, go to BUS.
  - op & bad: no bus transaction, stall=0. Go to DONE with err=1 registered (pulse in the DONE cycle). rdata unchanged.
  - !op: stall=0, stay IDLE.
- BUS:
  - stall=1. bus_req, bus_we, bus_addr, bus_wdata held stable.
  - bus_ack=1: bus_req=0 at the edge. On a read, rdata<=bus_rdata. Go to DONE, err=0.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 with no ack, bus_req=0 at the edge, rdata<=0 on a read, err=1, go to DONE.
  - Ack in the same cycle as the timeout boundary: ack wins, normal completion.
- DONE:
  - stall=0 for exactly one cycle so EX/MEM and MEM/WB advance. err is valid this cycle only.
  - Always returns to IDLE; no new op is accepted in DONE because the inputs still reflect the completing instruction.
- Latency: zero-wait-state bus (ack in first BUS cycle) gives stall high for 2 cycles (IDLE-detect, BUS), then DONE. Each extra wait cycle adds one stall cycle.
- rdata holds its value until the next completed read or reset. Writes do not change rdata.
- bus_ack while bus_req=0 is ignored.
- Inputs that change during BUS are ignored; the latched copies are used.
- stall is combinational from state and inputs. No other output is combinational.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with mem_read=mem_write=0 → stall=0, bus_req=0, rdata=0, err=0 every cycle.
- Zero-wait load: mem_read=1, addr=0x10; bus_ack=1 with bus_rdata=0xDEADBEEF_00000007 in the first BUS cycle → stall=1 for exactly 2 cycles, bus_we=0, bus_addr=0x10, rdata=0xDEADBEEF_00000007 in DONE, err=0.
- Store with 3 wait cycles: mem_write=1, addr=0x18, wdata=0x55; ack on the 4th BUS cycle → bus_we=1, bus_wdata=0x55 stable for 4 cycles, stall=1 for 5 cycles, rdata unchanged.
- Misaligned and conflicting: addr=0x13 with mem_read=1 → no bus_req, err=1 one cycle, stall=0 throughout. Repeat with mem_read=mem_write=1 at addr=0x8 → same response.
- Timeout: load with bus_ack held 0 → bus_req drops after exactly 15 BUS cycles, err=1 and rdata=0 in DONE. Separately, ack on the 15th cycle → normal completion, err=0.
- Reset mid-access and stray ack: rst=0 during the 2nd BUS cycle → bus_req=0 and stall=0 next cycle. A subsequent bus_ack=1 while idle → no state change.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: multi-cycle data-memory access controller between EX/MEM and MEM/WB
// Runs one req/ack bus transaction per load/store, stalling the pipeline until it completes.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic op, bad, ack, tmo;
  assign op  = mem_read | mem_write;
  assign bad = (addr[2:0] != 3'd0) | (mem_read & mem_write);
  assign ack = (state == BUS) & bus_req & bus_ack;
  // an ack on the final allowed cycle takes priority over the abort
  assign tmo = (state == BUS) & !ack & (cnt == 8'(TIMEOUT - 1));
  always_comb begin
    state_n = IDLE;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        stall   = op & !bad;
        state_n = op ? (bad ? DONE : BUS) : IDLE;
      end
      BUS: begin
        stall   = 1'b1;
        state_n = (ack | tmo) ? DONE : BUS;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op & bad) err <= 1'b1;
          if (op & !bad) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            cnt       <= '0;
          end
        end
        BUS: begin
          if (ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= bus_rdata;
          end else if (tmo) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            if (!bus_we) rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
